// File: rtl/result_checker.sv
// result_checker
// Self-checking stage behind the clocked adder. It compares each accepted sum
// against its golden value, keeps a saturating mismatch count, latches the
// address of the first mismatch of a run, and compacts every accepted sum into
// a 32-bit MISR signature.
//
// Optional feature macro: RESULT_CHECKER_MISR_EN
//   defined   -> signature is a 32-bit MISR seeded to 0xFFFFFFFF on start/reset
//   undefined -> no MISR logic, signature is tied to 0
//
// Ports
//   pll_clock        in   clock
//   reset            in   asynchronous active-high reset
//   start            in   one-cycle pulse arming a run (IDLE/DONE only)
//   num_tests        in   samples per run, 0..2^ADDR_WIDTH (sampled on start)
//   in_valid         in   in_addr/sum_in/exp_in qualify this cycle
//   in_addr          in   result address of the sample
//   sum_in           in   adder output
//   exp_in           in   golden expected sum
//   busy             out  run in progress (RUN or FLUSH)
//   done             out  run finished, results stable
//   err_count        out  saturating mismatch count
//   first_err_valid  out  a mismatch has been captured this run
//   first_err_addr   out  address of the first mismatch
//   signature        out  MISR state
module result_checker #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH = 11
) (
  input  logic                  pll_clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   num_tests,
  input  logic                  in_valid,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [WIDTH-1:0]      sum_in,
  input  logic [WIDTH-1:0]      exp_in,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           err_count,
  output logic                  first_err_valid,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic [31:0]           signature
);

  localparam int unsigned CNT_W = ADDR_WIDTH + 1;
  localparam int unsigned ERR_W = 16;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  // FSM and run bookkeeping
  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]      ntests_q, ntests_d;
  logic [CNT_W-1:0]      cnt_inc;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  // Stage-1 sample register
  logic                  s1_valid_q, s1_valid_d;
  logic [ADDR_WIDTH-1:0] s1_addr_q, s1_addr_d;
  logic [WIDTH-1:0]      s1_sum_q, s1_sum_d;
  logic [WIDTH-1:0]      s1_exp_q, s1_exp_d;

  // Stage-2 results
  logic [ERR_W-1:0]      err_count_q, err_count_d;
  logic                  fev_q, fev_d;
  logic [ADDR_WIDTH-1:0] fea_q, fea_d;
  logic                  mismatch;

`ifdef RESULT_CHECKER_MISR_EN
  localparam int unsigned NWORDS   = (WIDTH + 31) / 32;
  localparam int unsigned PADW     = NWORDS * 32;
  localparam logic [31:0] SIG_SEED = 32'hFFFF_FFFF;
  localparam logic [31:0] SIG_POLY = 32'h0040_0007;

  logic [31:0] sig_q, sig_d;

  // XOR of the zero-padded sum taken 32 bits at a time
  function automatic logic [31:0] fold32(input logic [WIDTH-1:0] v);
    logic [PADW-1:0] p;
    logic [31:0]     acc;
    p   = PADW'(v);
    acc = '0;
    for (int unsigned i = 0; i < NWORDS; i++) begin
      acc = acc ^ p[i*32 +: 32];
    end
    return acc;
  endfunction
`endif

  assign cnt_inc  = cnt_q + CNT_W'(1);
  assign mismatch = (s1_sum_q != s1_exp_q);

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ntests_d    = ntests_q;
    s1_valid_d  = 1'b0;
    s1_addr_d   = s1_addr_q;
    s1_sum_d    = s1_sum_q;
    s1_exp_d    = s1_exp_q;
    err_count_d = err_count_q;
    fev_d       = fev_q;
    fea_d       = fea_q;
`ifdef RESULT_CHECKER_MISR_EN
    sig_d       = sig_q;
`endif

    // Stage 2: fold the previously accepted sample into the results
    if (s1_valid_q) begin
      if (mismatch) begin
        if (err_count_q != ERR_MAX) begin
          err_count_d = err_count_q + ERR_W'(1);
        end
        if (!fev_q) begin
          fev_d = 1'b1;
          fea_d = s1_addr_q;
        end
      end
`ifdef RESULT_CHECKER_MISR_EN
      sig_d = {sig_q[30:0], 1'b0} ^ (sig_q[31] ? SIG_POLY : 32'h0)
              ^ fold32(s1_sum_q);
`endif
    end

    // Stage 1 and control; a start clears the results of the previous run
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          cnt_d       = '0;
          ntests_d    = num_tests;
          err_count_d = '0;
          fev_d       = 1'b0;
          fea_d       = '0;
`ifdef RESULT_CHECKER_MISR_EN
          sig_d       = SIG_SEED;
`endif
          state_d     = (num_tests == '0) ? S_FLUSH : S_RUN;
        end
      end
      S_RUN: begin
        if (in_valid) begin
          s1_valid_d = 1'b1;
          s1_addr_d  = in_addr;
          s1_sum_d   = sum_in;
          s1_exp_d   = exp_in;
          cnt_d      = cnt_inc;
          if (cnt_inc == ntests_q) begin
            state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_RUN) || (state_d == S_FLUSH);
    done_d = (state_d == S_DONE);
  end

  // State registers
  always_ff @(posedge pll_clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      ntests_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_addr_q   <= '0;
      s1_sum_q    <= '0;
      s1_exp_q    <= '0;
      err_count_q <= '0;
      fev_q       <= 1'b0;
      fea_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ntests_q    <= ntests_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      s1_valid_q  <= s1_valid_d;
      s1_addr_q   <= s1_addr_d;
      s1_sum_q    <= s1_sum_d;
      s1_exp_q    <= s1_exp_d;
      err_count_q <= err_count_d;
      fev_q       <= fev_d;
      fea_q       <= fea_d;
    end
  end

`ifdef RESULT_CHECKER_MISR_EN
  // MISR register
  always_ff @(posedge pll_clock or posedge reset) begin
    if (reset) begin
      sig_q <= SIG_SEED;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign signature = sig_q;
`else
  assign signature = 32'h0;
`endif

  assign busy            = busy_q;
  assign done            = done_q;
  assign err_count       = err_count_q;
  assign first_err_valid = fev_q;
  assign first_err_addr  = fea_q;

endmodule
